mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multicycle control unit for the MIPS datapath. A registered state machine sequences each instruction through fetch, decode, execute, memory and write-back cycles. It waits on a memory ready handshake with a configurable timeout and generates per-cycle datapath strobes. Illegal opcodes and memory timeouts drive it into a sticky fault state.

## Interface
- ALUOP_W, 5: width of alu_op; must be ≥5.
- MEM_TIMEOUT, 15: maximum wait cycles on one memory access before fault; range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  current IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access on this edge.
- zero  in  1  ALU zero flag, used in BRANCH.
- pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a, signed_or_not, link  out  1 each  datapath strobes.
- alu_src_b  out  2  00 reg, 01 const 4, 10 imm, 11 imm<<2.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr).
- alu_op  out  ALUOP_W  operation code.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse in an instruction's final cycle.
- fault  out  1  sticky error flag.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, FAULT=15.
- Outputs are decoded from the registered state and instr (Moore). The exceptions are the gated pc_write and ir_write.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=2, pc_source=00. pc_write=ir_write=mem_ready. Go to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=2. Next state by opcode instr[31:26]:
  - 000000, funct≠001000 → EXEC.
  - 000000, funct=001000 (jr) → JUMP.
  - 000010 or 000011 → JUMP.
  - 000100 or 000101 → BRANCH.
  - 001000, 001001, 001100, 001101, 001010, 001111 → I_EXEC.
  - 100100, 100101, 100011, 101000, 101001, 101011 → MEM_ADDR.
  - Anything else → FAULT.
- alu_op per opcode:
  - R-type 0, addi 1, addiu 2, andi 3, beq 4, bne 5, j 6, jal 7.
  - lbu 8, lhu 9, lui 10, lw 11, ori 12, slti 13, sb 15, sh 16, sw 17.
  - Upper bits are zero-extended to ALUOP_W.
- signed_or_not=1 in I_EXEC/I_WB for addi, andi, lui, ori, slti; 0 otherwise.
- EXEC: alu_src_a=1, alu_src_b=00. Then R_WB: reg_dst=1, reg_write=1, instr_done=1. Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. Then I_WB: reg_write=1, reg_dst=0, instr_done=1. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_source=01, instr_done=1. pc_write=(beq&zero)|(bne&~zero). Then FETCH.
- JUMP: pc_write=1, instr_done=1. pc_source=11 for jr, else 10. For jal also link=1 and reg_write=1 ($31 ← PC). Then FETCH.
- Wait counter (8 bits):
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - Clears on state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 → FAULT.
- FAULT: fault=1. All strobes 0. Held until rst_n is asserted (taken low).
- Strobes not listed for a state are 0.

## Timing
- Reset (asynchronous): state=FETCH, wait counter=0, fault=0, instr_done=0.
  - Outputs then follow FETCH decoding: mem_read=1, alu_src_b=01, alu_op=2, others 0.
  - pc_write and ir_write follow mem_ready.
- Reset asserted mid-instruction aborts it immediately; no strobe from the aborted state persists past the reset edge.
- Zero-wait-state latency in cycles: R-type 4, I-type 4, load 5, store 4, branch 3, jump 3.
  - Each wait cycle adds 1 in FETCH/MEM_RD/MEM_WR.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_ready=1 on exactly cycle MEM_TIMEOUT of waiting completes normally. The fault occurs only when the counter has reached MEM_TIMEOUT and mem_ready=0.
- instr changing outside DECODE does not affect next-state selection. Later states decode from instr, which the IR holds stable.

## Test plan
- Reset, then add (op 0, funct 100000) with mem_ready=1 → states 0,1,6,7,0. reg_dst=reg_write=1 only in R_WB. instr_done pulses in cycle 4.
- lw with mem_ready low for 3 cycles in MEM_RD → 8 cycles total. mem_read and i_or_d held during the wait. mem_to_reg=1 in MEM_WB.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → pc_write in BRANCH is 1, 0, 1. pc_source=01 each time.
- jal → DECODE then JUMP. pc_write=link=reg_write=1, pc_source=10. jr → pc_source=11, reg_write=0.
- Opcode 111111 → FAULT after DECODE; fault stays 1 for 20 cycles. rst_n low → state=0, fault=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 → FAULT entered after 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle → normal DECODE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle control unit for the MIPS datapath.
//
// A registered state machine steps each instruction through fetch, decode, execute, memory and
// write-back cycles. The datapath strobes are decoded from the registered state and the IR
// contents. The only exceptions are pc_write/ir_write in FETCH, pc_write in BRANCH and
// instr_done in MEM_WR, which also depend on the current mem_ready or zero input.
// Memory accesses wait on mem_ready under a bounded wait counter. Illegal opcodes and memory
// timeouts park the machine in a sticky FAULT state that only reset leaves.
//
// Parameters:
//   ALUOP_W      width of alu_op (>= 5)
//   MEM_TIMEOUT  not-ready cycles allowed on one memory access (1..255)
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   instr               IR contents, valid from DECODE onward
//   mem_ready           memory completes the current access on this edge
//   zero                ALU zero flag, used in BRANCH
//   pc_write .. link    single-bit datapath strobes
//   alu_src_b           00 reg, 01 const 4, 10 imm, 11 imm<<2
//   pc_source           00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   alu_op              ALU operation code
//   state               current state (debug)
//   instr_done          pulse in an instruction's final cycle
//   fault               sticky error flag
module mips_multicycle_control #(
    parameter int unsigned ALUOP_W     = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               signed_or_not,
    output logic               link,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state,
    output logic               instr_done,
    output logic               fault
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11,
        StFault   = 4'd15
    } ctrlStateT;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLbu   = 6'b100100;
    localparam logic [5:0] OpLhu   = 6'b100101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpSh    = 6'b101001;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] FunctJr = 6'b001000;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    ctrlStateT   stateQ, stateD;
    logic [7:0]  waitCntQ, waitCntD;
    logic [7:0]  waitCntInc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        isJr;
    logic        waitState;
    logic        timedOut;
    logic        signedImm;
    logic [4:0]  opAlu;
    logic        unusedInstr;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign isJr        = (opcode == OpRType) && (funct == FunctJr);
    assign unusedInstr = ^instr[25:6];

    assign waitState  = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
    assign waitCntInc = waitCntQ + 8'd1;
    // This not-ready cycle is the MEM_TIMEOUT-th one: a ready on that cycle still completes.
    assign timedOut   = waitState && !mem_ready && (waitCntInc >= TimeoutVal);

    // Next state
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StFetch: if (mem_ready) stateD = StDecode;
            StDecode: begin
                case (opcode)
                    OpRType:                stateD = isJr ? StJump : StExec;
                    OpJ, OpJal:             stateD = StJump;
                    OpBeq, OpBne:           stateD = StBranch;
                    OpAddi, OpAddiu, OpAndi,
                    OpOri, OpSlti, OpLui:   stateD = StIExec;
                    OpLbu, OpLhu, OpLw,
                    OpSb, OpSh, OpSw:       stateD = StMemAddr;
                    default:                stateD = StFault;
                endcase
            end
            // Stores are 101xxx, loads 100xxx.
            StMemAddr: stateD = instr[29] ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) stateD = StMemWb;
            StMemWr:   if (mem_ready) stateD = StFetch;
            StExec:    stateD = StRWb;
            StIExec:   stateD = StIWb;
            StRWb, StIWb, StMemWb, StBranch, StJump: stateD = StFetch;
            StFault:   stateD = StFault;
            default:   stateD = StFault;
        endcase
        if (timedOut) stateD = StFault;
    end

    always_comb begin
        if (stateD != stateQ) begin
            waitCntD = 8'd0;
        end else if (waitState && !mem_ready) begin
            waitCntD = waitCntInc;
        end else begin
            waitCntD = waitCntQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StFetch;
            waitCntQ <= 8'd0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
        end
    end

    // Per-opcode ALU operation, used in every state after DECODE.
    always_comb begin
        case (opcode)
            OpRType: opAlu = 5'd0;
            OpAddi:  opAlu = 5'd1;
            OpAddiu: opAlu = 5'd2;
            OpAndi:  opAlu = 5'd3;
            OpBeq:   opAlu = 5'd4;
            OpBne:   opAlu = 5'd5;
            OpJ:     opAlu = 5'd6;
            OpJal:   opAlu = 5'd7;
            OpLbu:   opAlu = 5'd8;
            OpLhu:   opAlu = 5'd9;
            OpLui:   opAlu = 5'd10;
            OpLw:    opAlu = 5'd11;
            OpOri:   opAlu = 5'd12;
            OpSlti:  opAlu = 5'd13;
            OpSb:    opAlu = 5'd15;
            OpSh:    opAlu = 5'd16;
            OpSw:    opAlu = 5'd17;
            default: opAlu = 5'd0;
        endcase
    end

    assign signedImm = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpLui) ||
                       (opcode == OpOri) || (opcode == OpSlti);

    // Output decode
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        signed_or_not = 1'b0;
        link          = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = ALUOP_W'(opAlu);
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (stateQ)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_W'(5'd2);
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(5'd2);
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            StExec: begin
                alu_src_a = 1'b1;
            end
            StRWb: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                pc_source  = 2'b01;
                instr_done = 1'b1;
                pc_write   = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero);
            end
            StJump: begin
                pc_write   = 1'b1;
                instr_done = 1'b1;
                pc_source  = isJr ? 2'b11 : 2'b10;
                if (opcode == OpJal) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                end
            end
            StIExec: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                signed_or_not = signedImm;
            end
            StIWb: begin
                reg_write     = 1'b1;
                instr_done    = 1'b1;
                signed_or_not = signedImm;
            end
            StFault: begin
                alu_op = '0;
                fault  = 1'b1;
            end
            default: begin
                alu_op = '0;
            end
        endcase
    end

    assign state = stateQ;

endmodule
